// File: rtl/dog_phys_scheduler.sv
// Per-tick sequencer for the shared dog physics engine: one update per alive dog,
// then one collision check per alive pair (a<b), each guarded by a watchdog.
module dog_phys_scheduler #(
    parameter int NUM_DOGS  = 8,
    parameter int FRAME_DIV = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [7:0] alive,
    output logic       upd_req,
    output logic [2:0] upd_idx,
    input  logic       upd_done,
    output logic       col_req,
    output logic [2:0] col_a,
    output logic [2:0] col_b,
    input  logic       col_done,
    output logic       busy,
    output logic       tick_done,
    output logic       overrun,
    output logic       fault,
    input  logic       flags_clr
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UPD_SEL  = 3'd1,
        S_UPD_WAIT = 3'd2,
        S_COL_SEL  = 3'd3,
        S_COL_WAIT = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] LAST_IDX  = 3'(NUM_DOGS - 1);
    localparam logic [2:0] LAST_A    = 3'(NUM_DOGS - 2);
    localparam logic [3:0] DIV_LAST  = 4'(FRAME_DIV - 1);
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t     r_state, w_state;
    logic [2:0] r_idx, w_idx;
    logic [2:0] r_a, w_a;
    logic [2:0] r_b, w_b;
    logic [7:0] r_latched, w_latched;
    logic [3:0] r_div, w_div;
    logic [7:0] r_wdog, w_wdog;
    logic       r_upd_req, w_upd_req;
    logic [2:0] r_upd_idx, w_upd_idx;
    logic       r_col_req, w_col_req;
    logic [2:0] r_col_a, w_col_a;
    logic [2:0] r_col_b, w_col_b;
    logic       r_busy, w_busy;
    logic       r_tick_done, w_tick_done;
    logic       r_overrun, w_overrun;
    logic       r_fault, w_fault;
    logic       w_fault_set;

    logic       w_timeout;
    logic       w_upd_end;
    logic       w_pair_end;
    logic       w_pair_wrap;
    logic [2:0] w_next_a;
    logic [2:0] w_next_b;

    assign w_timeout   = (r_wdog == WDOG_LAST);
    assign w_upd_end   = (r_idx == LAST_IDX);
    assign w_pair_wrap = (r_b == LAST_IDX);
    assign w_pair_end  = w_pair_wrap && (r_a == LAST_A);
    // Lexicographic pair walk: bump b, and on wrap restart b just above the new a.
    assign w_next_a    = w_pair_wrap ? (r_a + 3'd1) : r_a;
    assign w_next_b    = w_pair_wrap ? (r_a + 3'd2) : (r_b + 3'd1);

    assign upd_req   = r_upd_req;
    assign upd_idx   = r_upd_idx;
    assign col_req   = r_col_req;
    assign col_a     = r_col_a;
    assign col_b     = r_col_b;
    assign busy      = r_busy;
    assign tick_done = r_tick_done;
    assign overrun   = r_overrun;
    assign fault     = r_fault;

    // Next-state and next-output logic for the scheduler FSM and its flags.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_a         = r_a;
        w_b         = r_b;
        w_latched   = r_latched;
        w_div       = r_div;
        w_wdog      = r_wdog;
        w_upd_req   = r_upd_req;
        w_upd_idx   = r_upd_idx;
        w_col_req   = r_col_req;
        w_col_a     = r_col_a;
        w_col_b     = r_col_b;
        w_busy      = r_busy;
        w_tick_done = 1'b0;
        w_fault_set = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    if (r_div == DIV_LAST) begin
                        w_div     = 4'd0;
                        w_latched = alive;
                        w_idx     = 3'd0;
                        w_busy    = 1'b1;
                        w_state   = S_UPD_SEL;
                    end else begin
                        w_div = r_div + 4'd1;
                    end
                end else begin
                    w_div = r_div;
                end
            end
            S_UPD_SEL: begin
                if (r_latched[r_idx]) begin
                    w_state   = S_UPD_WAIT;
                    w_upd_req = 1'b1;
                    w_upd_idx = r_idx;
                    w_wdog    = 8'd0;
                end else if (w_upd_end) begin
                    w_state = S_COL_SEL;
                    w_a     = 3'd0;
                    w_b     = 3'd1;
                end else begin
                    w_idx = r_idx + 3'd1;
                end
            end
            S_UPD_WAIT: begin
                // A completion sampled on the watchdog's last cycle still counts as done.
                if (upd_done || w_timeout) begin
                    w_upd_req   = 1'b0;
                    w_fault_set = !upd_done;
                    if (w_upd_end) begin
                        w_state = S_COL_SEL;
                        w_a     = 3'd0;
                        w_b     = 3'd1;
                    end else begin
                        w_state = S_UPD_SEL;
                        w_idx   = r_idx + 3'd1;
                    end
                end else begin
                    w_wdog = r_wdog + 8'd1;
                end
            end
            S_COL_SEL: begin
                if (r_latched[r_a] && r_latched[r_b]) begin
                    w_state   = S_COL_WAIT;
                    w_col_req = 1'b1;
                    w_col_a   = r_a;
                    w_col_b   = r_b;
                    w_wdog    = 8'd0;
                end else if (w_pair_end) begin
                    w_state     = S_DONE;
                    w_tick_done = 1'b1;
                end else begin
                    w_a = w_next_a;
                    w_b = w_next_b;
                end
            end
            S_COL_WAIT: begin
                if (col_done || w_timeout) begin
                    w_col_req   = 1'b0;
                    w_fault_set = !col_done;
                    if (w_pair_end) begin
                        w_state     = S_DONE;
                        w_tick_done = 1'b1;
                    end else begin
                        w_state = S_COL_SEL;
                        w_a     = w_next_a;
                        w_b     = w_next_b;
                    end
                end else begin
                    w_wdog = r_wdog + 8'd1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state   = S_IDLE;
                w_busy    = 1'b0;
                w_upd_req = 1'b0;
                w_col_req = 1'b0;
            end
        endcase

        // Setting a sticky flag wins over a same-cycle clear.
        if (frame_start && r_busy) begin
            w_overrun = 1'b1;
        end else if (flags_clr) begin
            w_overrun = 1'b0;
        end else begin
            w_overrun = r_overrun;
        end

        if (w_fault_set) begin
            w_fault = 1'b1;
        end else if (flags_clr) begin
            w_fault = 1'b0;
        end else begin
            w_fault = r_fault;
        end
    end

    // State and registered-output update; reset aborts any tick in flight.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_a         <= 3'd0;
            r_b         <= 3'd0;
            r_latched   <= 8'd0;
            r_div       <= 4'd0;
            r_wdog      <= 8'd0;
            r_upd_req   <= 1'b0;
            r_upd_idx   <= 3'd0;
            r_col_req   <= 1'b0;
            r_col_a     <= 3'd0;
            r_col_b     <= 3'd0;
            r_busy      <= 1'b0;
            r_tick_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_a         <= w_a;
            r_b         <= w_b;
            r_latched   <= w_latched;
            r_div       <= w_div;
            r_wdog      <= w_wdog;
            r_upd_req   <= w_upd_req;
            r_upd_idx   <= w_upd_idx;
            r_col_req   <= w_col_req;
            r_col_a     <= w_col_a;
            r_col_b     <= w_col_b;
            r_busy      <= w_busy;
            r_tick_done <= w_tick_done;
            r_overrun   <= w_overrun;
            r_fault     <= w_fault;
        end
    end

endmodule

// File: doc/dog_phys_scheduler.md
Name: dog_phys_scheduler

Overview:
- Sequences the shared physics/collision datapath of the 8-dog game once per game tick.
- Triggered by the frame-start pulse at vsync onset (vertical blanking).
- Issues one position-update request per alive dog, then one collision-check request per alive dog pair (i<j), over req/done handshakes.
- Sits between the VGA timing generator and the single physics engine instance in the game top.

Parameters:
- NUM_DOGS, 8, number of dog slots; index width is 3 bits; the design is only required to support 8.
- FRAME_DIV, 1, run one tick every FRAME_DIV frame_start pulses (1..15).
- TIMEOUT, 255, max cycles a request may stay outstanding before it is aborted (1..255).

Ports:
- clk50  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse at vsync onset
- alive  in  8  per-dog alive mask; sampled only on tick start
- upd_req  out  1  position-update request to the physics engine
- upd_idx  out  3  dog index for the update request
- upd_done  in  1  engine completion for the update request
- col_req  out  1  collision-check request
- col_a  out  3  first dog of the pair (col_a < col_b)
- col_b  out  3  second dog of the pair
- col_done  in  1  engine completion for the collision check
- busy  out  1  high while a tick is in progress
- tick_done  out  1  single-cycle pulse when a tick completes
- overrun  out  1  sticky: frame_start arrived while busy
- fault  out  1  sticky: a request timed out
- flags_clr  in  1  clears overrun and fault

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; frame divider counter 0; latched mask 0; watchdog 0.
  - Reset mid-tick aborts immediately: any request drops at once and no tick_done is produced.
- All outputs are registered.
- Frame divider:
  - Each frame_start in IDLE increments the divider counter.
  - When the counter equals FRAME_DIV-1, a tick starts: counter returns to 0, alive is latched, state goes to UPD_SEL with idx=0, and busy=1 from the next cycle.
- States: IDLE, UPD_SEL, UPD_WAIT, COL_SEL, COL_WAIT, DONE.
- UPD_SEL (one cycle):
  - If latched_alive[idx]=1: go to UPD_WAIT with upd_req=1 and upd_idx=idx, both visible the following cycle.
  - Otherwise advance idx. After idx 7, go to COL_SEL with (a,b)=(0,1).
- UPD_WAIT:
  - upd_req is held high and upd_idx held stable.
  - On the cycle upd_done=1 is sampled, upd_req goes 0 in the next cycle and idx advances (same rule as UPD_SEL).
- COL_SEL (one cycle per candidate pair):
  - Request only if both latched_alive[a] and latched_alive[b] are set; otherwise skip.
  - Pair order is lexicographic: (0,1),(0,2)..(0,7),(1,2)..(6,7), 28 pairs.
  - Advance rule: b++. If b was 7, then a++ and b=a+1. After (6,7), go to DONE.
- COL_WAIT:
  - Same handshake as UPD_WAIT, using col_req/col_done; col_a and col_b are held stable.
- DONE: tick_done=1 for one cycle, busy=0 in the next cycle, return to IDLE.
- Handshake rules:
  - At most one of upd_req/col_req is high at any time.
  - A done input sampled while its req is low is ignored.
  - The minimum gap between consecutive requests is 1 cycle (the SEL cycle).
- Watchdog:
  - Counts cycles in UPD_WAIT/COL_WAIT and clears on entry to each wait.
  - If it reaches TIMEOUT without done: fault is set, req drops, and the scheduler advances as if done had arrived.
- Overrun:
  - frame_start while busy=1 sets overrun, is otherwise ignored, and does not advance the divider.
  - frame_start on the same cycle as tick_done counts as overrun.
- Flags:
  - flags_clr clears overrun and fault the next cycle.
  - A same-cycle set has priority over the clear.
- Empty mask: with alive=0, the tick walks 8+28 SEL cycles with no requests, then pulses tick_done.
- Total tick length with no waits: 1 start + 8 + 28 SEL cycles + 1 DONE.

Test Plan:
- Reset, FRAME_DIV=1, alive=8'hFF, engine acks each request 2 cycles after req rises -> 8 upd_req for idx 0..7, then 28 col_req in lexicographic order, exactly one tick_done; busy drops the cycle after tick_done.
- alive=8'b1000_0101 -> updates only for idx 0,2,7; collisions only (0,2),(0,7),(2,7); tick_done after 36+ cycles.
- upd_done withheld on idx 3 with TIMEOUT=16 -> upd_req high exactly 16 cycles, fault=1, next request is idx 4; flags_clr then returns fault to 0.
- Second frame_start 10 cycles into a tick -> overrun=1, tick continues unaffected, single tick_done; FRAME_DIV=3 -> ticks only on the 3rd, 6th, ... pulse.
- rst_n pulsed low while col_req is high -> col_req, busy and all flags go 0 asynchronously; the next frame_start restarts at upd_idx 0.
- Spurious upd_done/col_done pulses in IDLE and SEL states -> no state change, no index advance.
